// File: rtl/neosd_pkg.sv
// Shared types and constants for the SD command-line controller.
// Response-type and FSM-state enums, CRC7 polynomial, frame lengths and a serial CRC7 step.
package neosd_pkg;

  typedef enum logic [1:0] {
    RSP_NONE      = 2'd0,
    RSP_SHORT_CRC = 2'd1,
    RSP_SHORT     = 2'd2,
    RSP_LONG      = 2'd3
  } rsp_type_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX       = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RX       = 3'd3,
    ST_NCC      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift-out
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CMD_FRAME_LEN  = 48;
  localparam int LONG_FRAME_LEN = 136;
  localparam int CRC_COVER_LEN  = 40;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/neosd_cmd_ctrl_if.sv
// Host-side command/status bus of the SD command-line controller.
// start_i is a request qualified by busy_o: it is accepted only in a cycle where busy_o=0,
// and done_o pulses once per accepted start; status and rsp_o hold from done_o until the next accept.
interface neosd_cmd_ctrl_if;
  logic         start_i;
  logic [5:0]   cmd_idx_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   rsp_type_i;
  logic         busy_o;
  logic         done_o;
  logic         err_timeout_o;
  logic         err_crc_o;
  logic [127:0] rsp_o;

  modport master (
    output start_i, cmd_idx_i, cmd_arg_i, rsp_type_i,
    input  busy_o, done_o, err_timeout_o, err_crc_o, rsp_o
  );

  modport slave (
    input  start_i, cmd_idx_i, cmd_arg_i, rsp_type_i,
    output busy_o, done_o, err_timeout_o, err_crc_o, rsp_o
  );
endinterface

// File: rtl/neosd_crc7.sv
// Serial CRC7 accumulator shared by command transmit and response receive.
// clr has priority over en; feeding din=crc[6] shifts the remainder out unchanged.
module neosd_crc7
  import neosd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/neosd_cmd_ctrl.sv
// SD CMD-line controller: sends a 48-bit command frame, optionally receives a 48/136-bit
// response with timeout and CRC/end-bit checks, then idles NCC_CYCLES sd_clk periods.
module neosd_cmd_ctrl
  import neosd_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   clkstrb_i,
  input  logic                   sd_clk_en_i,
  output logic                   sd_clk_req_o,
  neosd_cmd_ctrl_if.slave        host,
  output logic                   sd_cmd_o,
  output logic                   sd_cmd_oe_o,
  input  logic                   sd_cmd_i,
  output state_t                 dbg_state_o
);

  localparam int TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int NCC_W = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES + 1) : 1;
  localparam int CNT_W = (NCC_W > 8) ? NCC_W : 8;

  state_t             state, state_nxt;
  rsp_type_t          rsp_type;
  logic               tick, accept;
  logic [39:0]        tx_sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [127:0]       rx_sr, rx_sr_nxt;
  logic [127:0]       rsp;
  logic               err_timeout, err_crc;
  logic [6:0]         crc;
  logic               crc_clr, crc_en, crc_din;
  logic               tx_bit, rx_last, tmo_hit;

  assign tick      = clkstrb_i & sd_clk_en_i;
  assign accept    = host.start_i & (state == ST_IDLE);
  assign tmo_hit   = (tmo_cnt == TMO_W'(RSP_TIMEOUT - 1));
  assign rx_sr_nxt = {rx_sr[126:0], sd_cmd_i};
  assign rx_last   = (rsp_type == RSP_LONG) ? (bit_cnt == CNT_W'(LONG_FRAME_LEN - 1))
                                            : (bit_cnt == CNT_W'(CMD_FRAME_LEN - 1));

  assign sd_clk_req_o       = (state != ST_IDLE) && (state != ST_DONE);
  assign host.busy_o        = (state != ST_IDLE);
  assign host.done_o        = (state == ST_DONE);
  assign host.err_timeout_o = err_timeout;
  assign host.err_crc_o     = err_crc;
  assign host.rsp_o         = rsp;
  assign dbg_state_o        = state;

  neosd_crc7 u_crc7 (
    .clk  (clk_i),
    .rstn (rstn_i),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (crc_din),
    .crc  (crc)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 1'b0;
    tx_bit    = 1'b1;
    if (bit_cnt < CNT_W'(CRC_COVER_LEN)) begin
      tx_bit = tx_sr[39];
    end else if (bit_cnt < CNT_W'(CMD_FRAME_LEN - 1)) begin
      tx_bit = crc[6];
    end
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_TX;
          crc_clr   = 1'b1;
        end
      end
      ST_TX: begin
        if (tick) begin
          if (bit_cnt < CNT_W'(CMD_FRAME_LEN - 1)) begin
            crc_en  = 1'b1;
            crc_din = tx_bit;
          end else begin
            state_nxt = (rsp_type == RSP_NONE) ? ST_NCC : ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        crc_clr = 1'b1;
        if (tick) begin
          if (!sd_cmd_i) begin
            state_nxt = ST_RX;
          end else if (tmo_hit) begin
            state_nxt = ST_NCC;
          end
        end
      end
      ST_RX: begin
        if (tick) begin
          // start bit is already in; CRC covers received bits 47:8
          if (bit_cnt < CNT_W'(CRC_COVER_LEN)) begin
            crc_en  = 1'b1;
            crc_din = sd_cmd_i;
          end
          if (rx_last) begin
            state_nxt = ST_NCC;
          end
        end
      end
      ST_NCC: begin
        if (tick && (bit_cnt == CNT_W'(NCC_CYCLES - 1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The end bit stays on the line for a full sd_clk period; the driver is released on the next tick.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_sr       <= '0;
      rsp_type    <= RSP_NONE;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      rx_sr       <= '0;
      rsp         <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe_o <= 1'b0;
    end else if (accept) begin
      tx_sr       <= {2'b01, host.cmd_idx_i, host.cmd_arg_i};
      rsp_type    <= rsp_type_t'(host.rsp_type_i);
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      rx_sr       <= '0;
      rsp         <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_TX: begin
          sd_cmd_o    <= tx_bit;
          sd_cmd_oe_o <= 1'b1;
          tx_sr       <= {tx_sr[38:0], 1'b0};
          bit_cnt     <= (bit_cnt == CNT_W'(CMD_FRAME_LEN - 1)) ? '0 : bit_cnt + CNT_W'(1);
        end
        ST_WAIT_RSP: begin
          sd_cmd_o    <= 1'b1;
          sd_cmd_oe_o <= 1'b0;
          if (!sd_cmd_i) begin
            bit_cnt <= CNT_W'(1);
            rx_sr   <= rx_sr_nxt;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_RX: begin
          sd_cmd_o    <= 1'b1;
          sd_cmd_oe_o <= 1'b0;
          rx_sr       <= rx_sr_nxt;
          if (rx_last) begin
            bit_cnt <= '0;
            if (rsp_type == RSP_LONG) begin
              rsp <= rx_sr_nxt;
            end else begin
              rsp <= {96'd0, rx_sr_nxt[39:8]};
            end
            if (rsp_type == RSP_SHORT_CRC) begin
              err_crc <= (crc != rx_sr_nxt[7:1]) | ~sd_cmd_i;
            end else begin
              err_crc <= ~sd_cmd_i;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_NCC: begin
          sd_cmd_o    <= 1'b1;
          sd_cmd_oe_o <= 1'b0;
          bit_cnt     <= bit_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/neosd_cmd_ctrl.md
NEOSD_CMD_CTRL -- requirements
Module: neosd_cmd_ctrl

Interface
REQ-001 Parameter RSP_TIMEOUT, default 64, sd_clk strobes allowed from end of command to response start bit.
REQ-002 Parameter NCC_CYCLES, default 8, idle sd_clk strobes after each transaction.
REQ-003 clk_i  in  1  system clock; all logic on rising edge.
REQ-004 rstn_i  in  1  asynchronous active-low reset.
REQ-005 clkstrb_i  in  1  one-cycle strobe at sd_clk falling edge; the only cycles that shift or sample.
REQ-006 sd_clk_en_i  in  1  SD clock running and not stalled; a strobe counts only when clkstrb_i & sd_clk_en_i (a "tick").
REQ-007 sd_clk_req_o  out  1  SD clock request to the clock generator.
REQ-008 start_i  in  1  one-cycle command start request; accepted only while busy_o=0.
REQ-009 cmd_idx_i  in  6  command index; cmd_arg_i  in  32  argument; rsp_type_i  in  2  0 none, 1 short+CRC, 2 short no CRC, 3 long (136 bit).
REQ-010 busy_o  out  1  transaction in progress; done_o  out  1  one-cycle completion pulse.
REQ-011 err_timeout_o, err_crc_o  out  1 each  status of last transaction, valid from done_o until next accepted start.
REQ-012 rsp_o  out  128  short: response bits 39:8 in rsp_o[31:0], rest 0; long: response bits 127:0 in rsp_o[127:0].
REQ-013 sd_cmd_o, sd_cmd_oe_o  out  1 each  CMD line drive and enable; sd_cmd_i  in  1  CMD line input.

Function
REQ-014 On accepted start, inputs are latched into internal registers the same cycle; busy_o=1 the next cycle.
REQ-015 States: IDLE, TX, WAIT_RSP, RX, NCC, DONE.
REQ-016 IDLE->TX on accepted start; sd_clk_req_o=1 in every state except IDLE and DONE.
REQ-017 TX: 48 bits MSB first on successive ticks: '0','1', cmd_idx, cmd_arg, CRC7, '1'; sd_cmd_oe_o=1 from first tick through tick after the end bit.
REQ-018 CRC7 polynomial x^7+x^3+1, initial 0, over the 40 bits following start bit inclusive of transmission bit.
REQ-019 TX->NCC if rsp_type=0, else TX->WAIT_RSP, after the end-bit tick; sd_cmd_oe_o=0 in WAIT_RSP, RX, NCC.
REQ-020 WAIT_RSP: sd_cmd_i sampled each tick; 0 -> RX (start bit counted as bit 0); RSP_TIMEOUT ticks without 0 -> err_timeout_o=1, -> NCC.
REQ-021 RX: receive 48 (types 1,2) or 136 (type 3) bits total; shift sampled bits in MSB first.
REQ-022 Type 1: CRC7 over received bits 47:8 compared with bits 7:1; mismatch or end bit 0 -> err_crc_o=1; types 2,3 check end bit only.
REQ-023 NCC: NCC_CYCLES ticks then DONE; DONE: done_o=1 one cycle, busy_o=0 next cycle, -> IDLE.
REQ-024 start_i while busy_o=1 is ignored, no effect on state or registers.
REQ-025 Cycles without a tick hold all state; sd_clk_en_i=0 for any duration stretches the transaction, no timeout accrual.
REQ-026 Bit and timeout counters wide enough for 136 and RSP_TIMEOUT; no wrap-around within one transaction.
REQ-027 Error flags and rsp_o cleared on accepted start.

Reset
REQ-028 Asynchronous reset: state IDLE, all outputs 0, sd_cmd_o=1 value held internally but sd_cmd_oe_o=0.
REQ-029 Reset mid-transaction aborts immediately; no done_o pulse after release.

Structure
REQ-030 Package neosd_pkg holds rsp_type enum, state enum, CRC7 polynomial constant, frame length constants (48, 136).
REQ-031 Sub-module neosd_crc7: serial CRC7, clear/enable/data inputs, 7-bit output; one instance shared by TX and RX.

Verification
REQ-032 CMD0, arg 0x00000000, type 0 -> CMD line 0x400000000095, done_o after 48+8 ticks, no errors.
REQ-033 CMD8, arg 0x000001AA, type 1, card returns 0x08000001AA13 -> TX frame 0x48000001AA87, rsp_o[31:0]=0x000001AA, err_crc_o=0.
REQ-034 Same as REQ-033 with one response bit flipped -> err_crc_o=1, done_o still pulses.
REQ-035 Type 1, CMD held high -> err_timeout_o=1 after exactly 64 ticks in WAIT_RSP, done_o after 8 further ticks.
REQ-036 Type 3 response of 136 bits with sd_clk_en_i dropped for 20 cycles mid-RX -> rsp_o equals bits 127:0 unchanged.
REQ-037 rstn_i low at TX bit 20 -> sd_cmd_oe_o=0 and busy_o=0 asynchronously; new start after release transmits full frame.
